// File: rtl/posit_extract_pkg.sv
// ============================================================================
// posit_defines : shared posit format helpers (field widths, format selector)
// Rev 1.0
// ============================================================================
`default_nettype none

package posit_defines;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    AMULT  = 1'b1
  } posit_format_e;

  // AMULT keeps the hidden bit and widens the scale for a product
  function automatic int get_fraction_width(input int n, input int es, input posit_format_e fmt);
    return (fmt == NORMAL) ? (n - es - 3) : (n - es - 2);
  endfunction

  function automatic int get_scale_width(input int n, input int es, input posit_format_e fmt);
    return (fmt == NORMAL) ? ($clog2(n) + es + 1) : ($clog2(n) + es + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/posit_extract_if.sv
// ============================================================================
// posit_extract_if : rts/rtr stream bus carrying packed posits in, decoded out
// Rev 1.0
// ============================================================================
`default_nettype none

interface posit_extract_if
  import posit_defines::*;
#(
  parameter int POSIT_WIDTH = 16,
  parameter int POSIT_ES    = 1
);
  localparam int FRAC_W  = get_fraction_width(POSIT_WIDTH, POSIT_ES, NORMAL);
  localparam int SCALE_W = get_scale_width(POSIT_WIDTH, POSIT_ES, NORMAL);

  logic                      rtr_o;
  logic                      rts_i;
  logic                      sow_i;
  logic                      eow_i;
  logic [POSIT_WIDTH-1:0]    posit_i;
  logic                      rtr_i;
  logic                      rts_o;
  logic                      sow_o;
  logic                      eow_o;
  logic [FRAC_W-1:0]         fraction_o;
  logic signed [SCALE_W-1:0] scale_o;
  logic                      NaR_o;
  logic                      zero_o;
  logic                      sign_o;

  modport slave (
    input  rts_i, sow_i, eow_i, posit_i, rtr_i,
    output rtr_o, rts_o, sow_o, eow_o, fraction_o, scale_o, NaR_o, zero_o, sign_o
  );

  modport master (
    output rts_i, sow_i, eow_i, posit_i, rtr_i,
    input  rtr_o, rts_o, sow_o, eow_o, fraction_o, scale_o, NaR_o, zero_o, sign_o
  );

endinterface

`default_nettype wire

// File: rtl/posit_extract_lzc.sv
// ============================================================================
// posit_lzc : number of leading bits of vec_i equal to ref_i (combinational)
// Rev 1.0
// ============================================================================
`default_nettype none

module posit_lzc #(
  parameter int WIDTH = 15,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec_i,
  input  logic             ref_i,
  output logic [CNT_W-1:0] count_o
);

  logic done;

  always_comb begin
    count_o = '0;
    done    = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!done) begin
        if (vec_i[i] == ref_i) count_o = count_o + 1'b1;
        else                   done    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/posit_extract.sv
// ============================================================================
// posit_extract : 2-stage posit decoder (sign/zero/NaR, then regime/exp/frac)
// Rev 1.0
// ============================================================================
`default_nettype none

module posit_extract
  import posit_defines::*;
#(
  parameter int POSIT_WIDTH = 16,
  parameter int POSIT_ES    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  posit_extract_if.slave       bus
);

  localparam int N       = POSIT_WIDTH;
  localparam int ES      = POSIT_ES;
  localparam int FRAC_W  = get_fraction_width(N, ES, NORMAL);
  localparam int SCALE_W = get_scale_width(N, ES, NORMAL);
  localparam int RUN_W   = $clog2(N);
  localparam int EF_W    = N - 3;

  logic process_en, receive;
  logic rtr_q, rtr_d, latched_q, latched_d, latch_sow_q, latch_sow_d, latch_eow_q, latch_eow_d;
  logic [N-1:0] latch_posit_q, latch_posit_d, in_posit;
  logic in_sow, in_eow;

  logic s1_staged_q, s1_staged_d, s1_sign_q, s1_sign_d, s1_zero_q, s1_zero_d;
  logic s1_nar_q, s1_nar_d, s1_sow_q, s1_sow_d, s1_eow_q, s1_eow_d;
  logic [N-2:0] s1_body_q, s1_body_d;

  logic s2_staged_q, s2_staged_d, s2_sign_q, s2_sign_d, s2_zero_q, s2_zero_d;
  logic s2_nar_q, s2_nar_d, s2_sow_q, s2_sow_d, s2_eow_q, s2_eow_d;
  logic [FRAC_W-1:0]  s2_frac_q, s2_frac_d;
  logic [SCALE_W-1:0] s2_scale_q, s2_scale_d;

  logic               r0;
  logic [RUN_W-1:0]   run;
  logic [EF_W-1:0]    ef;
  logic [SCALE_W-1:0] run_ext, k_val, e_ext, scale_val;

  always_comb begin
    process_en    = bus.rtr_i | ~s2_staged_q;
    receive       = bus.rts_i & rtr_q;
    rtr_d         = process_en;
    latched_d     = latched_q;
    latch_posit_d = latch_posit_q;
    latch_sow_d   = latch_sow_q;
    latch_eow_d   = latch_eow_q;
    // A word accepted while stalled would otherwise be lost: park it here
    if (process_en) begin
      latched_d = 1'b0;
    end else if (receive) begin
      latched_d     = 1'b1;
      latch_posit_d = bus.posit_i;
      latch_sow_d   = bus.sow_i;
      latch_eow_d   = bus.eow_i;
    end
    in_posit = latched_q ? latch_posit_q : bus.posit_i;
    in_sow   = latched_q ? latch_sow_q   : bus.sow_i;
    in_eow   = latched_q ? latch_eow_q   : bus.eow_i;
  end

  always_comb begin
    s1_staged_d = s1_staged_q;
    s1_sign_d   = s1_sign_q;
    s1_zero_d   = s1_zero_q;
    s1_nar_d    = s1_nar_q;
    s1_body_d   = s1_body_q;
    s1_sow_d    = s1_sow_q;
    s1_eow_d    = s1_eow_q;
    if (process_en) begin
      s1_staged_d = receive | latched_q;
      if (receive | latched_q) begin
        s1_sign_d = in_posit[N-1];
        s1_zero_d = (in_posit == '0);
        s1_nar_d  = (in_posit == {1'b1, {(N-1){1'b0}}});
        s1_body_d = in_posit[N-1] ? (~in_posit[N-2:0] + 1'b1) : in_posit[N-2:0];
        s1_sow_d  = in_sow;
        s1_eow_d  = in_eow;
      end
    end
  end

  assign r0 = s1_body_q[N-2];

  posit_lzc #(
    .WIDTH (N - 1),
    .CNT_W (RUN_W)
  ) u_lzc (
    .vec_i   (s1_body_q),
    .ref_i   (r0),
    .count_o (run)
  );

  // Body bits below the shortest regime+terminator, shifted by the extra regime length
  assign ef        = s1_body_q[N-4:0] << (run - 1'b1);
  assign run_ext   = {{(SCALE_W-RUN_W){1'b0}}, run};
  assign k_val     = r0 ? (run_ext - 1'b1) : (~run_ext + 1'b1);
  assign scale_val = (k_val << ES) | e_ext;

  generate
    if (ES > 0) begin : g_exp
      assign e_ext = {{(SCALE_W-ES){1'b0}}, ef[EF_W-1 -: ES]};
    end else begin : g_no_exp
      assign e_ext = '0;
    end
  endgenerate

  always_comb begin
    s2_staged_d = s2_staged_q;
    s2_sign_d   = s2_sign_q;
    s2_zero_d   = s2_zero_q;
    s2_nar_d    = s2_nar_q;
    s2_frac_d   = s2_frac_q;
    s2_scale_d  = s2_scale_q;
    s2_sow_d    = s2_sow_q;
    s2_eow_d    = s2_eow_q;
    if (process_en) begin
      s2_staged_d = s1_staged_q;
      s2_sign_d   = s1_sign_q;
      s2_zero_d   = s1_zero_q;
      s2_nar_d    = s1_nar_q;
      s2_frac_d   = (s1_zero_q | s1_nar_q) ? '0 : ef[FRAC_W-1:0];
      s2_scale_d  = (s1_zero_q | s1_nar_q) ? '0 : scale_val;
      s2_sow_d    = s1_sow_q;
      s2_eow_d    = s1_eow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtr_q <= 1'b0; latched_q <= 1'b0; latch_posit_q <= '0;
      latch_sow_q <= 1'b0; latch_eow_q <= 1'b0;
      s1_staged_q <= 1'b0; s1_sign_q <= 1'b0; s1_zero_q <= 1'b0; s1_nar_q <= 1'b0;
      s1_body_q <= '0; s1_sow_q <= 1'b0; s1_eow_q <= 1'b0;
      s2_staged_q <= 1'b0; s2_sign_q <= 1'b0; s2_zero_q <= 1'b0; s2_nar_q <= 1'b0;
      s2_frac_q <= '0; s2_scale_q <= '0; s2_sow_q <= 1'b0; s2_eow_q <= 1'b0;
    end else begin
      rtr_q <= rtr_d; latched_q <= latched_d; latch_posit_q <= latch_posit_d;
      latch_sow_q <= latch_sow_d; latch_eow_q <= latch_eow_d;
      s1_staged_q <= s1_staged_d; s1_sign_q <= s1_sign_d; s1_zero_q <= s1_zero_d; s1_nar_q <= s1_nar_d;
      s1_body_q <= s1_body_d; s1_sow_q <= s1_sow_d; s1_eow_q <= s1_eow_d;
      s2_staged_q <= s2_staged_d; s2_sign_q <= s2_sign_d; s2_zero_q <= s2_zero_d; s2_nar_q <= s2_nar_d;
      s2_frac_q <= s2_frac_d; s2_scale_q <= s2_scale_d; s2_sow_q <= s2_sow_d; s2_eow_q <= s2_eow_d;
    end
  end

  assign bus.rtr_o      = rtr_q;
  assign bus.rts_o      = s2_staged_q;
  assign bus.sow_o      = s2_sow_q;
  assign bus.eow_o      = s2_eow_q;
  assign bus.fraction_o = s2_frac_q;
  assign bus.scale_o    = s2_scale_q;
  assign bus.NaR_o      = s2_nar_q;
  assign bus.zero_o     = s2_zero_q;
  assign bus.sign_o     = s2_sign_q;

endmodule

`default_nettype wire
